sum_tx_sequencer: RTL and testbench

SUM_TX_SEQUENCER -- requirements
Module: sum_tx_sequencer

---
 rtl/sum_tx_pkg.sv | 47 ++++
 rtl/sum_tx_sequencer_if.sv | 10 +
 rtl/sum_tx_sequencer_sync.sv | 24 ++
 rtl/sum_tx_sequencer.sv | 152 +++++++++++++++
 tb/tb_sum_tx_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sum_tx_pkg.sv
// Shared types and ASCII constants for the sum transmit sequencer.
// frame_byte() defines the layout of one frame: "A+B=SS\r\n".
package sum_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } state_t;

  localparam int FRAME_LEN_DEFAULT = 8;

  localparam logic [7:0] ASCII_PLUS    = 8'h2B;
  localparam logic [7:0] ASCII_EQ      = 8'h3D;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_HEX_OFS = 8'h37;

  // 'A' is 0x41, which is 0x37 + 10.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) begin
      return ASCII_ZERO + {4'h0, n};
    end
    return ASCII_HEX_OFS + {4'h0, n};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [4:0] sum);
    logic [7:0] res;
    case (idx)
      3'd0:    res = hex_char(a);
      3'd1:    res = ASCII_PLUS;
      3'd2:    res = hex_char(b);
      3'd3:    res = ASCII_EQ;
      3'd4:    res = hex_char({3'b000, sum[4]});
      3'd5:    res = hex_char(sum[3:0]);
      3'd6:    res = ASCII_CR;
      default: res = ASCII_LF;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sum_tx_sequencer_if.sv
// Byte-stream handshake between the sequencer and a UART transmitter.
// A byte moves on every clock where tx_valid and tx_ready are both high.
interface sum_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sum_tx_sequencer_sync.sv
// Two-flop synchronizer for an active-low asynchronous strobe with a
// one-cycle pulse on each synchronized 1->0 transition.
module sync_fall_detect (
  input  logic clk,
  input  logic reset,
  input  logic pin_n,
  output logic fall
);

  // [0] metastable stage, [1] synchronized level, [2] previous level.
  // Resetting every stage to 1 prevents a spurious edge after reset.
  logic [2:0] sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= 3'b111;
    end else begin
      sync_reg <= {sync_reg[1:0], pin_n};
    end
  end

  assign fall = sync_reg[2] & ~sync_reg[1];

endmodule

// File: rtl/sum_tx_sequencer.sv
// Latches two nibbles via async strobes and streams "A+B=SS\r\n" to a
// UART transmitter; a B strobe requests a frame, repeats collapse into one.
module sum_tx_sequencer
  import sum_tx_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           save_a_n,
  input  logic           save_b_n,
  input  logic [3:0]     data_input,
  sum_tx_if.master       tx,
  output logic           busy,
  output logic [4:0]     sum_out
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  logic [1:0] strobe_n;
  logic [1:0] fall;

  assign strobe_n = {save_b_n, save_a_n};

  for (genvar gi = 0; gi < 2; gi++) begin : g_strobe
    sync_fall_detect u_sync (
      .clk   (clk),
      .reset (reset),
      .pin_n (strobe_n[gi]),
      .fall  (fall[gi])
    );
  end

  // Same depth as the strobe synchronizers so data and edge stay aligned.
  logic [3:0] data_meta_reg;
  logic [3:0] data_sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_meta_reg <= 4'hF;
      data_sync_reg <= 4'hF;
    end else begin
      data_meta_reg <= data_input;
      data_sync_reg <= data_meta_reg;
    end
  end

  state_t     state_reg,    state_next;
  logic [3:0] a_reg,        a_next;
  logic [3:0] b_reg,        b_next;
  logic       pending_reg,  pending_next;
  logic [3:0] snap_a_reg,   snap_a_next;
  logic [3:0] snap_b_reg,   snap_b_next;
  logic [4:0] sum_reg,      sum_next;
  logic [2:0] idx_reg,      idx_next;
  logic [7:0] tx_data_reg,  tx_data_next;
  logic       tx_valid_reg, tx_valid_next;
  logic [4:0] sum_calc;

  assign sum_calc = {1'b0, a_reg} + {1'b0, b_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      a_reg        <= 4'h0;
      b_reg        <= 4'h0;
      pending_reg  <= 1'b0;
      snap_a_reg   <= 4'h0;
      snap_b_reg   <= 4'h0;
      sum_reg      <= 5'h00;
      idx_reg      <= 3'd0;
      tx_data_reg  <= 8'h00;
      tx_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      pending_reg  <= pending_next;
      snap_a_reg   <= snap_a_next;
      snap_b_reg   <= snap_b_next;
      sum_reg      <= sum_next;
      idx_reg      <= idx_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    pending_next  = pending_reg;
    snap_a_next   = snap_a_reg;
    snap_b_next   = snap_b_reg;
    sum_next      = sum_reg;
    idx_next      = idx_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;

    if (fall[0]) begin
      a_next = data_sync_reg;
    end
    if (fall[1]) begin
      b_next       = data_sync_reg;
      pending_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        snap_a_next   = a_reg;
        snap_b_next   = b_reg;
        sum_next      = sum_calc;
        // A B edge landing in this very cycle is a new request, keep it.
        if (!fall[1]) begin
          pending_next = 1'b0;
        end
        idx_next      = 3'd0;
        tx_valid_next = 1'b1;
        tx_data_next  = frame_byte(3'd0, a_reg, b_reg, sum_calc);
        state_next    = SEND;
      end
      SEND: begin
        if (tx_valid_reg && tx.tx_ready) begin
          if (idx_reg == LAST_IDX) begin
            tx_valid_next = 1'b0;
            state_next    = WAIT;
          end else begin
            idx_next     = idx_reg + 3'd1;
            tx_data_next = frame_byte(idx_reg + 3'd1, snap_a_reg, snap_b_reg, sum_reg);
          end
        end
      end
      WAIT: begin
        state_next = pending_reg ? LOAD : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign tx.tx_data  = tx_data_reg;
  assign tx.tx_valid = tx_valid_reg;
  assign sum_out     = sum_reg;
  assign busy        = (state_reg != IDLE) || pending_reg;

endmodule

// File: tb/tb_sum_tx_sequencer.sv
// Directed bench for sum_tx_sequencer: a queue of expected frame bytes is
// built from plain arithmetic and checked on every accepted byte.
module tb_sum_tx_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       save_a_n = 1'b1;
  logic       save_b_n = 1'b1;
  logic [3:0] data_input = 4'h0;
  logic       busy;
  logic [4:0] sum_out;

  sum_tx_if tx_bus ();

  sum_tx_sequencer #(.FRAME_LEN(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .save_a_n   (save_a_n),
    .save_b_n   (save_b_n),
    .data_input (data_input),
    .tx         (tx_bus),
    .busy       (busy),
    .sum_out    (sum_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ready_mode = 0;

  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];
  int         log_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] m_hex(input int n);
    if (n < 10) return 8'(48 + n);
    return 8'(65 + n - 10);
  endfunction

  task automatic push_frame(input int a, input int b);
    int s;
    s = a + b;
    exp_q.push_back(m_hex(a));
    exp_q.push_back(8'h2B);
    exp_q.push_back(m_hex(b));
    exp_q.push_back(8'h3D);
    exp_q.push_back(m_hex(s / 16));
    exp_q.push_back(m_hex(s % 16));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Compare process: byte order, hold stability, no bytes beyond the model.
  logic       hold = 1'b0;
  logic [7:0] hold_data = 8'h00;
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          n_cmp++;
          if (tx_bus.tx_valid !== 1'b1 || tx_bus.tx_data !== hold_data) begin
            n_bad++;
            $display("FAIL hold: got valid=%b data=0x%0h, expected valid=1 data=0x%0h",
                     tx_bus.tx_valid, tx_bus.tx_data, hold_data);
          end
        end
        if (tx_bus.tx_valid === 1'b1 && tx_bus.tx_ready === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", tx_bus.tx_data);
          end else begin
            e = exp_q.pop_front();
            if (tx_bus.tx_data !== e) begin
              n_bad++;
              $display("FAIL byte: got 0x%0h, expected 0x%0h", tx_bus.tx_data, e);
            end
          end
          log_q.push_back(tx_bus.tx_data);
          log_cyc.push_back(cyc);
          $display("byte 0x%0h accepted at cycle %0d", tx_bus.tx_data, cyc);
        end
        hold = (tx_bus.tx_valid === 1'b1) && (tx_bus.tx_ready !== 1'b1);
        hold_data = tx_bus.tx_data;
      end
    end
  end

  // Ready driver: always ready, or one cycle in four.
  initial begin
    tx_bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_bus.tx_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
    end
  end

  task automatic strobe(input bit do_a, input bit do_b, input logic [3:0] v);
    @(negedge clk);
    data_input = v;
    @(negedge clk);
    if (do_a) save_a_n = 1'b0;
    if (do_b) save_b_n = 1'b0;
    repeat (4) @(negedge clk);
    save_a_n = 1'b1;
    save_b_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    check({name, "_queue_left"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_log(input int target);
    int t;
    t = 0;
    while (log_q.size() < target && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("wait_log_timeout", (log_q.size() >= target), 32'd1);
  endtask

  task automatic check_lit(input string name, input int base, input logic [7:0] lit[8]);
    if (log_q.size() < base + 8) begin
      check({name, "_count"}, log_q.size(), base + 8);
    end else begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("%s_b%0d", name, i), log_q[base + i], lit[i]);
      end
    end
  endtask

  initial begin
    logic [7:0] lit[8];
    int base;
    int n_before;

    $display("test reset");
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, tx_bus.tx_valid}, 32'd0);
    check("rst_data", tx_bus.tx_data, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum", sum_out, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("test A=3 B=4");
    base = log_q.size();
    push_frame(3, 4);
    strobe(1, 0, 4'h3);
    strobe(0, 1, 4'h4);
    wait_idle("s1");
    check("s1_sum", sum_out, 32'd7);
    lit = '{8'h33, 8'h2B, 8'h34, 8'h3D, 8'h30, 8'h37, 8'h0D, 8'h0A};
    check_lit("s1", base, lit);
    if (log_cyc.size() >= base + 8) check("s1_back_to_back", log_cyc[base + 7] - log_cyc[base], 32'd7);

    $display("test A=F B=F");
    base = log_q.size();
    push_frame(15, 15);
    strobe(1, 0, 4'hF);
    strobe(0, 1, 4'hF);
    wait_idle("s2");
    check("s2_sum", sum_out, 32'h1E);
    lit = '{8'h46, 8'h2B, 8'h46, 8'h3D, 8'h31, 8'h45, 8'h0D, 8'h0A};
    check_lit("s2", base, lit);

    $display("test A=9 B=A ready 1-of-4");
    base = log_q.size();
    push_frame(9, 10);
    ready_mode = 1;
    strobe(1, 0, 4'h9);
    strobe(0, 1, 4'hA);
    wait_idle("s3");
    ready_mode = 0;
    check("s3_sum", sum_out, 32'h13);
    lit = '{8'h39, 8'h2B, 8'h41, 8'h3D, 8'h31, 8'h33, 8'h0D, 8'h0A};
    check_lit("s3", base, lit);

    $display("test B edge during frame");
    strobe(1, 0, 4'h1);
    base = log_q.size();
    push_frame(1, 1);
    push_frame(1, 2);
    @(negedge clk);
    data_input = 4'h1;
    @(negedge clk);
    save_b_n = 1'b0;
    repeat (4) @(negedge clk);
    save_b_n = 1'b1;
    data_input = 4'h2;
    @(negedge clk);
    save_b_n = 1'b0;
    repeat (4) @(negedge clk);
    save_b_n = 1'b1;
    repeat (2) @(negedge clk);
    wait_idle("s4");
    check("s4_sum", sum_out, 32'd3);
    lit = '{8'h31, 8'h2B, 8'h31, 8'h3D, 8'h30, 8'h32, 8'h0D, 8'h0A};
    check_lit("s4a", base, lit);
    lit = '{8'h31, 8'h2B, 8'h32, 8'h3D, 8'h30, 8'h33, 8'h0D, 8'h0A};
    check_lit("s4b", base + 8, lit);

    $display("test reset mid-frame");
    base = log_q.size();
    push_frame(2, 3);
    strobe(1, 0, 4'h2);
    strobe(0, 1, 4'h3);
    wait_log(base + 5);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("s5_valid_now", {31'd0, tx_bus.tx_valid}, 32'd0);
    check("s5_busy_now", {31'd0, busy}, 32'd0);
    check("s5_data_now", tx_bus.tx_data, 32'h00);
    check("s5_sum_now", sum_out, 32'd0);
    exp_q.delete();
    n_before = log_q.size();
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("s5_no_resume", log_q.size(), n_before);
    check("s5_busy_after", {31'd0, busy}, 32'd0);
    base = log_q.size();
    push_frame(0, 6);
    strobe(0, 1, 4'h6);
    wait_idle("s5");
    check("s5_sum", sum_out, 32'd6);
    lit = '{8'h30, 8'h2B, 8'h36, 8'h3D, 8'h30, 8'h36, 8'h0D, 8'h0A};
    check_lit("s5", base, lit);

    $display("test simultaneous A and B");
    base = log_q.size();
    push_frame(5, 5);
    strobe(1, 1, 4'h5);
    wait_idle("s6");
    check("s6_sum", sum_out, 32'h0A);
    lit = '{8'h35, 8'h2B, 8'h35, 8'h3D, 8'h30, 8'h41, 8'h0D, 8'h0A};
    check_lit("s6", base, lit);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected summary before 500000");
    $fatal(1, "watchdog");
  end

endmodule
